// File: rtl/channel_xform_if.sv
// Valid/ready channel bundle for channel_xform: an upstream beat interface
// (in_*, mode) and a downstream FIFO-head interface (out_*).
interface channel_xform_if #(
  parameter int NUM_CH = 3,
  parameter int W      = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [NUM_CH*W-1:0]   in_data;
  logic [2*NUM_CH-1:0]   mode;
  logic                  out_valid;
  logic                  out_ready;
  logic [NUM_CH*W-1:0]   out_data;

  // Block side: consumes input beats, produces the FIFO head.
  modport slave (
    input  in_valid, in_data, mode, out_ready,
    output in_ready, out_valid, out_data
  );

  // Environment side: drives beats and consumes the FIFO head.
  modport master (
    output in_valid, in_data, mode, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/channel_xform.sv
// Multi-channel transform stage: each accepted beat is transformed per channel
// (pass / invert / hold / zero) and pushed into a DEPTH-entry circular FIFO.
// The FIFO head is kept in its own register so out_data is reset to 0 and
// keeps showing the last popped entry while the FIFO is empty.
module channel_xform #(
  parameter int NUM_CH = 3,
  parameter int W      = 8,
  parameter int DEPTH  = 2,
  parameter int CW     = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  channel_xform_if.slave             bus,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [CW-1:0]              beat_cnt
);

  localparam int DW = NUM_CH * W;
  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    MODE_PASS = 2'b00,
    MODE_INV  = 2'b01,
    MODE_HOLD = 2'b10,
    MODE_ZERO = 2'b11
  } mode_e;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [DW-1:0] last_q;
  logic [DW-1:0] head_q;
  logic [DW-1:0] xform;
  logic          push;
  logic          pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // in_ready depends only on registered occupancy, never on out_ready.
  assign bus.in_ready  = (level < LW'(DEPTH));
  assign bus.out_valid = (level != '0);
  assign bus.out_data  = head_q;
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;

  // Per-channel transform of the incoming beat, using this cycle's mode.
  always_comb begin
    // NOTE: default assignment first so no path through the loop leaves xform unassigned (no latch).
    xform = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      case (mode_e'(bus.mode[2*c +: 2]))
        MODE_PASS: xform[c*W +: W] = bus.in_data[c*W +: W];
        MODE_INV:  xform[c*W +: W] = ~bus.in_data[c*W +: W];
        MODE_HOLD: xform[c*W +: W] = last_q[c*W +: W];
        default:   xform[c*W +: W] = '0;
      endcase
    end
  end

  // FIFO storage write on push.
  // NOTE: storage array is deliberately not reset; only pointers, level and the head register are, so reads never see stale data as valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= xform;
  end

  // Pointers, occupancy, beat counter, hold registers and head register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level    <= '0;
      beat_cnt <= '0;
      last_q   <= '0;
      head_q   <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= next_ptr(wr_ptr);
        beat_cnt <= beat_cnt + 1'b1;
        last_q   <= xform;
      end
      if (pop) rd_ptr <= next_ptr(rd_ptr);

      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase

      // Head tracks what rd_ptr will point at; it is left alone when the FIFO drains.
      if (push && (level == '0)) begin
        head_q <= xform;
      end else if (pop) begin
        if (level > LW'(1)) head_q <= mem[next_ptr(rd_ptr)];
        else if (push)      head_q <= xform;
      end
    end
  end

endmodule

// File: tb/tb_channel_xform.sv
// Directed testbench for channel_xform (NUM_CH=3, W=8, DEPTH=2, CW=4).
module tb_channel_xform;

  localparam int NUM_CH = 3;
  localparam int W      = 8;
  localparam int DEPTH  = 2;
  localparam int CW     = 4;

  logic          clk;
  logic          rst_n;
  logic [1:0]    level;
  logic [CW-1:0] beat_cnt;

  channel_xform_if #(.NUM_CH(NUM_CH), .W(W)) bus ();

  channel_xform #(.NUM_CH(NUM_CH), .W(W), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .level    (level),
    .beat_cnt (beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [23:0] data;
    logic [5:0]  mode;
    logic [23:0] exp;
  } vec_t;

  vec_t          vecs[9];
  int            n_checks = 0;
  int            n_fail   = 0;
  logic [CW-1:0] exp_cnt  = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n   = 1'b1;
    exp_cnt = '0;
  endtask

  // One beat into an empty FIFO with out_ready=1; checked the cycle after accept.
  task automatic send_one(input vec_t v);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = v.data;
    bus.mode     = v.mode;
    @(posedge clk);
    exp_cnt++;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check({v.name, " out_valid"}, 32'(bus.out_valid), 32'd1);
    check({v.name, " out_data"},  32'(bus.out_data),  32'(v.exp));
    check({v.name, " level"},     32'(level),         32'd1);
    check({v.name, " beat_cnt"},  32'(beat_cnt),      32'(exp_cnt));
  endtask

  initial begin
    vecs[0] = '{"pass",       24'h332211, 6'b000000, 24'h332211};
    vecs[1] = '{"mixed",      24'hAA0F5C, 6'b110100, 24'h00F05C};
    vecs[2] = '{"hold_seed",  24'h123456, 6'b000000, 24'h123456};
    vecs[3] = '{"hold1",      24'hFFFFFF, 6'b101010, 24'h123456};
    vecs[4] = '{"hold2",      24'hFFFFFF, 6'b101010, 24'h123456};
    vecs[5] = '{"invert",     24'h00FF81, 6'b010101, 24'hFF007E};
    vecs[6] = '{"per_ch",     24'h112233, 6'b100001, 24'hFF22CC};
    vecs[7] = '{"zero",       24'h123456, 6'b111111, 24'h000000};
    vecs[8] = '{"hold_zero",  24'h987654, 6'b101010, 24'h000000};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.mode      = '0;
    bus.out_ready = 1'b1;

    // Reset state
    #12;
    check("rst level",     32'(level),         32'd0);
    check("rst in_ready",  32'(bus.in_ready),  32'd1);
    check("rst out_valid", 32'(bus.out_valid), 32'd0);
    check("rst beat_cnt",  32'(beat_cnt),      32'd0);
    check("rst out_data",  32'(bus.out_data),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven transform vectors
    for (int i = 0; i < 9; i++) send_one(vecs[i]);

    // Hold as the first beat after reset yields zeros
    do_reset();
    send_one('{"hold_first", 24'hFFFFFF, 6'b101010, 24'h000000});

    // Backpressure and full
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.mode      = '0;
    bus.in_data   = 24'hA1A1A1;
    @(posedge clk);
    exp_cnt++;
    @(negedge clk);
    bus.in_data = 24'hB2B2B2;
    @(posedge clk);
    exp_cnt++;
    @(negedge clk);
    bus.in_data = 24'hC3C3C3;
    check("full level",     32'(level),        32'd2);
    check("full in_ready",  32'(bus.in_ready), 32'd0);
    check("full head",      32'(bus.out_data), 32'hA1A1A1);
    @(posedge clk);
    @(negedge clk);
    check("stall level",    32'(level),        32'd2);
    check("stall beat_cnt", 32'(beat_cnt),     32'(exp_cnt));
    check("stall head",     32'(bus.out_data), 32'hA1A1A1);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("drain1 level",    32'(level),        32'd1);
    check("drain1 in_ready", 32'(bus.in_ready), 32'd1);
    check("drain1 head",     32'(bus.out_data), 32'hB2B2B2);
    @(posedge clk);
    exp_cnt++;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("drain2 head",     32'(bus.out_data), 32'hC3C3C3);
    check("drain2 level",    32'(level),        32'd1);
    check("drain2 beat_cnt", 32'(beat_cnt),     32'(exp_cnt));
    @(posedge clk);
    @(negedge clk);
    check("drain3 level",     32'(level),         32'd0);
    check("drain3 out_valid", 32'(bus.out_valid), 32'd0);

    // Simultaneous push and pop at level 1
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 24'h000000;
    @(posedge clk);
    exp_cnt++;
    @(negedge clk);
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      bus.in_data = 24'h010101 * 24'(i);
      @(posedge clk);
      exp_cnt++;
      @(negedge clk);
      check($sformatf("pp%0d level", i), 32'(level),        32'd1);
      check($sformatf("pp%0d data", i),  32'(bus.out_data), 32'(24'h010101 * 24'(i)));
    end
    bus.in_valid = 1'b0;
    check("pp beat_cnt", 32'(beat_cnt), 32'(exp_cnt));
    @(posedge clk);
    @(negedge clk);

    // Counter wrap: 17 accepts with a 4-bit counter
    do_reset();
    bus.in_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bus.in_data = 24'(i);
      @(posedge clk);
      exp_cnt++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check("wrap beat_cnt", 32'(beat_cnt), 32'(exp_cnt));
    check("wrap head",     32'(bus.out_data), 32'd16);

    // Fill to level 2, then reset between clock edges
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 24'h555555;
    @(posedge clk);
    exp_cnt++;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("pre_rst level", 32'(level), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("async out_valid", 32'(bus.out_valid), 32'd0);
    check("async level",     32'(level),         32'd0);
    check("async in_ready",  32'(bus.in_ready),  32'd1);
    check("async beat_cnt",  32'(beat_cnt),      32'd0);
    check("async out_data",  32'(bus.out_data),  32'd0);
    @(negedge clk);
    rst_n         = 1'b1;
    exp_cnt       = '0;
    bus.out_ready = 1'b1;
    send_one('{"post_rst", 24'hC0FFEE, 6'b000001, 24'hC0FF11});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
